// File: rtl/home_status_pkg.sv
// Shared types and constants for the home status serial transmitter.
package home_status_pkg;

  localparam int FRAME_DATA_BITS = 9;
  localparam int FRAME_BITS      = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [2:0] DISP_IDLE          = 3'd0;
  localparam logic [2:0] DISP_FRONT_DOOR    = 3'd1;
  localparam logic [2:0] DISP_REAR_DOOR     = 3'd2;
  localparam logic [2:0] DISP_ALARM_BUZZER  = 3'd3;
  localparam logic [2:0] DISP_WINDOW_BUZZER = 3'd4;
  localparam logic [2:0] DISP_HEATER        = 3'd5;
  localparam logic [2:0] DISP_COOLER        = 3'd6;

  // Parity bit that brings the total ones count (data + parity) to even or odd.
  function automatic logic frame_parity(input logic [FRAME_DATA_BITS-1:0] data,
                                        input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/home_status_tx_if.sv
// Status inputs and serial outputs of the home status transmitter.
interface home_status_tx_if;
  logic [2:0] display;
  logic [5:0] temperature;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (output display, temperature, send_req,
                  input  tx, busy, frame_done);
  modport slave  (input  display, temperature, send_req,
                  output tx, busy, frame_done);
endinterface

// File: rtl/home_status_baud_tick.sv
// Bit-period cycle counter; bit_tick marks the last cycle of each bit period.
module home_status_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) cnt_d = '0;
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/home_status_tx.sv
// Sends a 12-bit status frame (display code, temperature, parity) to the
// remote panel whenever the display code changes or a send is requested.
//
//   state  | meaning
//   IDLE   | line high, waiting for a trigger
//   START  | start bit (0)
//   DATA   | 9 snapshot bits, LSB first
//   PARITY | parity bit
//   STOP   | stop bit (1); may chain straight into START
module home_status_tx
  import home_status_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EVEN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  home_status_tx_if.slave  bus
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
  localparam logic [2:0] PARITY = ST_PARITY;
  localparam logic [2:0] STOP   = ST_STOP;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_DATA_BITS - 1);

  logic [2:0]                 state_q, state_d;
  logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                       parity_q, parity_d;
  logic [3:0]                 idx_q, idx_d;
  logic [2:0]                 last_sent_q, last_sent_d;
  logic                       pending_q, pending_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;

  logic                       bit_tick;
  logic                       trigger;
  logic                       snapshot;
  logic [FRAME_DATA_BITS-1:0] snap_data;

  assign trigger   = bus.send_req || (bus.display != last_sent_q);
  assign snap_data = {bus.temperature, bus.display};

  home_status_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    idx_d        = idx_q;
    last_sent_d  = last_sent_q;
    pending_d    = pending_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    snapshot     = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) snapshot = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          frame_done_d = 1'b1;
          // A trigger landing in this very cycle is served here, never lost.
          if (pending_q || trigger) begin
            snapshot = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (state_q != IDLE && trigger && !snapshot) pending_d = 1'b1;

    if (snapshot) begin
      state_d     = START;
      tx_d        = 1'b0;
      shreg_d     = snap_data;
      parity_d    = frame_parity(snap_data, PARITY_EVEN != 0);
      last_sent_d = bus.display;
      pending_d   = 1'b0;
      idx_d       = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      idx_q        <= '0;
      last_sent_q  <= DISP_IDLE;
      pending_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      idx_q        <= idx_d;
      last_sent_q  <= last_sent_d;
      pending_q    <= pending_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_home_status_tx.sv
// Drives an even-parity and an odd-parity transmitter with identical stimulus
// and checks both against a frame-level reference model and scoreboard.
module tb_home_status_tx;
  localparam int CPB = 16;
  localparam int FB  = 12;

  logic       clk;
  logic       reset;
  logic [2:0] display;
  logic [5:0] temperature;
  logic       send_req;

  home_status_tx_if if_e();
  home_status_tx_if if_o();

  assign if_e.display     = display;
  assign if_e.temperature = temperature;
  assign if_e.send_req    = send_req;
  assign if_o.display     = display;
  assign if_o.temperature = temperature;
  assign if_o.send_req    = send_req;

  home_status_tx #(.CLKS_PER_BIT(CPB), .PARITY_EVEN(1)) u_dut_e (
    .clk(clk), .reset(reset), .bus(if_e));
  home_status_tx #(.CLKS_PER_BIT(CPB), .PARITY_EVEN(0)) u_dut_o (
    .clk(clk), .reset(reset), .bus(if_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FB-1:0] fe;
    logic [FB-1:0] fo;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         frames_seen = 0;
  int         left = 0;
  int         m_fd = 0;
  bit         pending = 0;
  bit         armed = 0;
  logic [2:0] last = 3'd0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  // Frame as seen on the wire, index = bit period: start, display, temperature, parity, stop.
  function automatic logic [FB-1:0] mk_frame(input logic [2:0] d, input logic [5:0] t,
                                             input bit even);
    int   ones;
    logic par;
    ones = $countones({t, d});
    par  = even ? (ones % 2 == 1) : (ones % 2 == 0);
    return {1'b1, par, t, d, 1'b0};
  endfunction

  // Reference model: 'left' counts cycles remaining in the frame on the line.
  always @(posedge clk) begin
    bit trig;
    if (reset) begin
      armed = 1'b1;
      if (left > 1 && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      left    = 0;
      pending = 1'b0;
      last    = 3'd0;
      m_fd    = 0;
    end else begin
      trig = send_req || (display != last);
      m_fd = (left == 1);
      if (left <= 1) begin
        if (trig || (left == 1 && pending)) begin
          exp_q.push_back('{fe: mk_frame(display, temperature, 1'b1),
                            fo: mk_frame(display, temperature, 1'b0)});
          last    = display;
          pending = 1'b0;
          left    = FB * CPB;
        end else begin
          left = 0;
        end
      end else begin
        if (trig) pending = 1'b1;
        left--;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int   pos;
    exp_t e;
    if (armed) begin
      chk("busy_e", int'(if_e.busy), int'(left > 0));
      chk("busy_o", int'(if_o.busy), int'(left > 0));
      chk("frame_done_e", int'(if_e.frame_done), m_fd);
      chk("frame_done_o", int'(if_o.frame_done), m_fd);
      if (if_e.frame_done) frames_seen++;
      if (left == 0) begin
        chk("idle_tx_e", int'(if_e.tx), 1);
        chk("idle_tx_o", int'(if_o.tx), 1);
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        pos = FB * CPB - left;
        chk("tx_bit_e", int'(if_e.tx), int'(exp_q[0].fe[pos / CPB]));
        chk("tx_bit_o", int'(if_o.tx), int'(exp_q[0].fo[pos / CPB]));
        if (left == 1) e = exp_q.pop_front();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    display     = 3'd0;
    temperature = 6'd0;
    send_req    = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(20);
    chk("no_frame_after_reset", frames_seen, 0);

    // display=5, temperature=30: start bit one cycle after the triggering edge.
    display     = 3'd5;
    temperature = 6'd30;
    tick(1);
    chk("start_latency_tx", int'(if_e.tx), 0);
    tick(250);
    chk("frames_after_first", frames_seen, 1);

    // Unchanged display sends nothing; send_req resends.
    tick(200);
    chk("no_resend_when_unchanged", frames_seen, 1);
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    tick(250);
    chk("frames_after_send_req", frames_seen, 2);

    // Mid-frame display changes collapse into one back-to-back frame.
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    tick(50);
    display = 3'd6;
    tick(50);
    display = 3'd2;
    tick(450);
    chk("frames_after_midframe_change", frames_seen, 4);

    // Reset in the middle of data bit 4, with a coincident send_req.
    display = 3'd1;
    tick(88);
    reset    = 1'b1;
    display  = 3'd0;
    send_req = 1'b1;
    tick(1);
    chk("reset_tx", int'(if_e.tx), 1);
    chk("reset_busy", int'(if_e.busy), 0);
    reset    = 1'b0;
    send_req = 1'b0;
    tick(300);
    chk("frames_after_reset", frames_seen, 4);

    // All-ones payload.
    display     = 3'd3;
    temperature = 6'd63;
    tick(250);
    chk("frames_after_ones", frames_seen, 5);

    // send_req in the final stop cycle chains the next frame.
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    tick(191);
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    chk("chain_frame_done", int'(if_e.frame_done), 1);
    chk("chain_start_tx", int'(if_e.tx), 0);
    tick(400);
    chk("frames_after_chain", frames_seen, 7);

    for (int i = 0; i < 6000; i++) begin
      reset    = ($urandom_range(0, 1499) == 0);
      send_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) display = 3'($urandom_range(0, 6));
      temperature = 6'($urandom_range(0, 63));
      tick(1);
    end
    reset    = 1'b0;
    send_req = 1'b0;
    tick(500);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/home_status_tx.md
HOME_STATUS_TX -- requirements
Module: home_status_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter PARITY_EVEN, default 1: 1 = even parity bit, 0 = odd parity bit.
REQ-003 clk  input  1  the single clock; all logic runs on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 display  input  3  current state code, same encoding as the system display output (0 idle, 1 front_door, 2 rear_door, 3 alarm_buzzer, 4 window_buzzer, 5 heater, 6 cooler).
REQ-006 temperature  input  6  raw temperature sensor value.
REQ-007 send_req  input  1  one-cycle pulse that forces a status frame even if display is unchanged.
REQ-008 tx  output  1  serial line to the remote status panel, idle high.
REQ-009 busy  output  1  high from the first start-bit cycle to the last stop-bit cycle.
REQ-010 frame_done  output  1  one-cycle pulse in the cycle after the last stop-bit cycle.

Function
REQ-011 Frame order SHALL be: start(0), display[0..2], temperature[0..5] (LSB first), parity, stop(1); 12 bits total, each held exactly CLKS_PER_BIT cycles.
REQ-012 The parity bit SHALL make the count of ones over the 9 data bits plus parity even (PARITY_EVEN=1) or odd (PARITY_EVEN=0).
REQ-013 A trigger SHALL be either send_req=1, or display != last_sent, where last_sent is the 3-bit code of the most recent frame (reset value 0).
REQ-014 In IDLE, a trigger sampled at edge N SHALL snapshot display and temperature into a 9-bit shift register, and tx SHALL go low for the start bit from edge N+1.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; START->DATA->PARITY->STOP each after CLKS_PER_BIT cycles; DATA SHALL last 9 bit periods, counted by a 4-bit index.
REQ-016 Snapshot data SHALL stay frozen during a frame; display/temperature changes mid-frame SHALL NOT alter the frame in flight.
REQ-017 A trigger arriving while busy SHALL set a 1-bit pending flag; multiple triggers during one frame SHALL collapse into one pending frame.
REQ-018 At the end of STOP, if pending=1 or display != last_sent, the FSM SHALL clear pending, take a fresh snapshot and enter START on the next cycle with no idle gap; otherwise it SHALL return to IDLE.
REQ-019 A trigger coinciding with the final STOP cycle SHALL be served by the back-to-back path of REQ-018 and SHALL NOT be lost.
REQ-020 last_sent SHALL update at snapshot time, not at frame end.
REQ-021 Bit timing SHALL use a cycle counter of width ceil(log2(CLKS_PER_BIT)) that wraps from CLKS_PER_BIT-1 to 0 and produces a bit_tick in the wrap cycle.
REQ-022 tx SHALL be driven from a register (glitch-free).

Reset
REQ-023 Reset asserted at any edge, including mid-frame, SHALL on that edge force: state IDLE, tx=1, busy=0, frame_done=0, pending=0, last_sent=0, bit counter and bit index 0.
REQ-024 A trigger sampled in the same cycle as reset SHALL be ignored.
REQ-025 After reset deasserts with display=0 and no send_req, no frame SHALL be sent.

Structure
REQ-026 A shared package home_status_pkg SHALL hold the state enum, FRAME_DATA_BITS=9, FRAME_BITS=12, and the display code constants.
REQ-027 One sub-module, home_status_baud_tick (cycle counter plus bit_tick, synchronous clear), SHALL be instantiated; everything else lives in the top module.

Verification
REQ-028 Reset, then display=5, temperature=30, CLKS_PER_BIT=16 -> tx low one cycle later; bits 1,0,1, 0,1,1,1,1,0, parity 0, stop 1; busy high 192 cycles; frame_done pulses once.
REQ-029 display held at 5 after REQ-028 -> no further frame; then send_req pulse -> identical frame resent.
REQ-030 Mid-frame display 5->6->2 -> current frame unchanged; exactly one back-to-back frame carrying code 2 with no idle-high cycle between stop and start.
REQ-031 Reset asserted during DATA bit 4 -> tx=1, busy=0 on that edge; no frame_done; after release with display=0, tx stays high.
REQ-032 PARITY_EVEN=0, display=3, temperature=63 -> 8 data ones, parity bit 1.
REQ-033 send_req in the final STOP cycle -> new frame starts the next cycle; frame_done and the new start bit fall in the same cycle.
